uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/uart_tx_scheduler.sv | 125 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding,
// the clocks-per-bit baud table (100 MHz system clock) and the reset baud constant.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } sched_state_t;

  localparam int BAUD_W = 15;

  // 9600 baud, selected out of reset.
  localparam logic [BAUD_W-1:0] BAUD_RESET_CLOCKS = 15'd10417;

  // Element k holds clocks-per-bit for br_select == k (4800 ... 230400 baud).
  localparam logic [7:0][BAUD_W-1:0] BAUD_TABLE = {
    15'd434, 15'd868, 15'd1736, 15'd2604,
    15'd5208, 15'd6945, 15'd10417, 15'd20834
  };

  function automatic logic [BAUD_W-1:0] baud_lookup(input logic [2:0] sel);
    return BAUD_TABLE[sel];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester found scanning upward
// from last_grant+1 (wrapping modulo N_REQ).
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid  = 1'b0;
    winner = last_grant;
    cand   = last_grant;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = IDX_W'((int'(last_grant) + off) % N_REQ);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler feeding bytes from N_REQ requesters to one UART transmitter.
// Optional packet locking is enabled by defining UART_TX_SCHED_LOCK_EN.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int BR_W  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
`ifdef UART_TX_SCHED_LOCK_EN
  input  logic [N_REQ-1:0]   lock,
`endif
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  input  logic [2:0]         br_select,
  input  logic               tx_ready,
  input  logic               rx_ready,
  output logic               tx_enable,
  output logic [7:0]         tx_data,
  output logic [BR_W-1:0]    br_clocks
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_t     state, state_next;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] arb_winner, pick_winner;
  logic             arb_valid, pick_valid;
  logic             launch_go;
  logic [N_REQ-1:0] last_onehot;
  logic [7:0]       pick_byte;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_rr_arbiter (
    .req       (req),
    .last_grant(last_grant),
    .valid     (arb_valid),
    .winner    (arb_winner)
  );

`ifdef UART_TX_SCHED_LOCK_EN
  // Set when the finished byte's owner had lock high; keeps that owner
  // selected for as long as it keeps both req and lock asserted.
  logic lock_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_hold <= 1'b0;
    end else if (state == ST_WAIT_DONE && tx_ready) begin
      lock_hold <= lock[last_grant];
    end
  end

  always_comb begin
    pick_valid  = arb_valid;
    pick_winner = arb_winner;
    if (lock_hold && req[last_grant] && lock[last_grant]) begin
      pick_valid  = 1'b1;
      pick_winner = last_grant;
    end
  end
`else
  assign pick_valid  = arb_valid;
  assign pick_winner = arb_winner;
`endif

  assign launch_go = (state == ST_IDLE) && pick_valid && tx_ready;

  always_comb begin
    pick_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_winner == IDX_W'(i)) pick_byte = req_data[8*i +: 8];
    end
  end

  always_comb begin
    last_onehot             = '0;
    last_onehot[last_grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (launch_go) state_next = ST_LAUNCH;
      ST_LAUNCH:    state_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (!tx_ready) state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (tx_ready) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // last_grant doubles as the current winner from LAUNCH through WAIT_DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IDX_W'(N_REQ - 1);
      tx_data    <= 8'h00;
      done       <= '0;
      br_clocks  <= BR_W'(BAUD_RESET_CLOCKS);
    end else begin
      done <= '0;
      if (state == ST_WAIT_DONE && tx_ready) done <= last_onehot;
      if (launch_go) begin
        tx_data    <= pick_byte;
        last_grant <= pick_winner;
      end
      if (state == ST_IDLE && tx_ready && rx_ready) begin
        br_clocks <= BR_W'(baud_lookup(br_select));
      end
    end
  end

  assign tx_enable = (state == ST_LAUNCH);
  assign grant     = (state == ST_LAUNCH) ? last_onehot : '0;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus pushes predicted grants/dones,
// a monitor pops and compares; a transmitter model drives tx_ready.
module tb_uart_tx_scheduler;

  localparam int N    = 4;
  localparam int BR_W = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     lock = '0;
  logic [8*N-1:0]   req_data = '0;
  logic [2:0]       br_select = 3'd1;
  logic             tx_ready = 1'b1;
  logic             rx_ready = 1'b1;
  logic [N-1:0]     grant, done;
  logic             tx_enable;
  logic [7:0]       tx_data;
  logic [BR_W-1:0]  br_clocks;

  uart_tx_scheduler #(.N_REQ(N), .BR_W(BR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
`ifdef UART_TX_SCHED_LOCK_EN
    .lock     (lock),
`endif
    .grant    (grant),
    .done     (done),
    .br_select(br_select),
    .tx_ready (tx_ready),
    .rx_ready (rx_ready),
    .tx_enable(tx_enable),
    .tx_data  (tx_data),
    .br_clocks(br_clocks)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         br;
  } exp_t;

  exp_t exp_grant_q[$];
  int   exp_done_q[$];
  int   observed_q[$];
  int   launch_cyc_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int model_last = N - 1;
  bit model_have_prev = 1'b0;
  logic [7:0] last_data = 8'h00;
  int busy_len = 5;
  bit busy_rand = 1'b0;
  int tx_d_max = 0;
  bit xfer_aborted = 1'b0;
  int baud_ref [8] = '{20834, 10417, 6945, 5208, 2604, 1736, 868, 434};

  task automatic finishTest();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: wait bound expired (t=%0t)", name, $time);
    finishTest();
  endtask

  task automatic applyStimulus(input int i, input logic [7:0] d);
    req[i] = 1'b1;
    req_data[8*i +: 8] = d;
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference arbitration: scan requesters in order starting after the previous winner.
  function automatic int model_pick(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic pushExpected();
    exp_t e;
    int   w;
    w = model_pick(req, model_last);
`ifdef UART_TX_SCHED_LOCK_EN
    if (model_have_prev && req[model_last] && lock[model_last]) w = model_last;
`endif
    e.idx  = w;
    e.data = req_data[8*w +: 8];
    e.br   = baud_ref[br_select];
    exp_grant_q.push_back(e);
    exp_done_q.push_back(w);
    model_last      = w;
    model_have_prev = 1'b1;
  endtask

  task automatic waitGrant();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (tx_enable === 1'b1) return;
    end
    timeoutFail("grant_timeout");
  endtask

  task automatic waitTxReady(input logic level);
    for (int k = 0; k < 100; k++) begin
      if (tx_ready === level) return;
      @(negedge clk);
    end
    timeoutFail("tx_ready_timeout");
  endtask

  task automatic drain();
    for (int k = 0; k < 400; k++) begin
      if (exp_grant_q.size() == 0 && exp_done_q.size() == 0) begin
        repeat (2) @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    timeoutFail("drain_timeout");
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    exp_grant_q.delete();
    exp_done_q.delete();
    model_last      = N - 1;
    model_have_prev = 1'b0;
    last_data       = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One byte: predict the next winner, wait for its launch, then update requests.
  task automatic runTransaction(input bit reraise, input bit random_adds);
    int w;
    logic [N-1:0] m;
    if (req == '0) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) if (m[i]) applyStimulus(i, 8'($urandom));
    end
    if (random_adds && $urandom_range(0, 3) == 0) br_select = 3'($urandom_range(0, 7));
    pushExpected();
    w = model_last;
    waitGrant();
    req[w] = 1'b0;
    if (reraise) applyStimulus(w, 8'($urandom));
    if (random_adds) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) applyStimulus(i, 8'($urandom));
      end
    end
  endtask

  // Transmitter model: goes busy after tx_enable, then idle again.
  initial begin
    int d, len;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_enable === 1'b1) begin
        d   = $urandom_range(0, tx_d_max);
        len = busy_rand ? $urandom_range(1, 12) : busy_len;
        @(posedge clk);
        repeat (d) @(posedge clk);
        #1 tx_ready = 1'b0;
        repeat (len) @(posedge clk);
        #1 tx_ready = 1'b1;
        if (xfer_aborted) begin
          xfer_aborted = 1'b0;
        end else begin
          @(negedge clk);
          checkOutput("done_early", 32'(done), 32'd0);
          @(negedge clk);
          checkOutput("done_timing", 32'(|done), 32'd1);
        end
      end
    end
  end

  // Monitor: compares every launch and done pulse against the scoreboard.
  initial begin
    exp_t e;
    int   di;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n === 1'b1) begin
        if (tx_enable === 1'b1 || grant != '0) begin
          if (exp_grant_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_grant: got %b required none", grant);
          end else begin
            e = exp_grant_q.pop_front();
            checkOutput("grant", 32'(grant), 32'(1) << e.idx);
            checkOutput("tx_enable", 32'(tx_enable), 32'd1);
            checkOutput("tx_data", 32'(tx_data), 32'(e.data));
            checkOutput("br_clocks_at_launch", 32'(br_clocks), 32'(e.br));
            last_data = e.data;
          end
          observed_q.push_back(idx_of(grant));
          launch_cyc_q.push_back(cyc);
        end else begin
          checkOutput("tx_data_hold", 32'(tx_data), 32'(last_data));
        end
        if (done != '0) begin
          if (exp_done_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_done: got %b required none", done);
          end else begin
            di = exp_done_q.pop_front();
            checkOutput("done", 32'(done), 32'(1) << di);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    timeoutFail("watchdog");
  end

  initial begin
    logic [N-1:0] done_seen;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset values");
    checkOutput("reset_br_clocks", 32'(br_clocks), 32'd10417);
    checkOutput("reset_grant", 32'(grant), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_tx_enable", 32'(tx_enable), 32'd0);
    checkOutput("reset_tx_data", 32'(tx_data), 32'd0);

    $display("[TB] single byte A5 with 20-cycle busy");
    busy_len = 20;
    observed_q.delete();
    applyStimulus(0, 8'hA5);
    runTransaction(1'b0, 1'b0);
    drain();
    checkOutput("a5_tx_data", 32'(tx_data), 32'h0A5);
    if (observed_q.size() > 0) checkOutput("a5_winner", 32'(observed_q[0]), 32'd0);
    else timeoutFail("a5_no_grant");

    $display("[TB] all four requesting, eight bytes");
    doReset();
    busy_len = 3;
    observed_q.delete();
    for (int i = 0; i < N; i++) applyStimulus(i, 8'($urandom));
    repeat (8) runTransaction(1'b1, 1'b0);
    req = '0;
    drain();
    checkOutput("rr_count", 32'(observed_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < observed_q.size()) checkOutput("rr_order", 32'(observed_q[i]), 32'(i % 4));
    end

    $display("[TB] single requester back-to-back spacing");
    busy_len = 1;
    launch_cyc_q.delete();
    applyStimulus(1, 8'h11);
    repeat (3) runTransaction(1'b1, 1'b0);
    req = '0;
    drain();
    for (int i = 1; i < 3; i++) begin
      if (i < launch_cyc_q.size())
        checkOutput("grant_spacing", 32'(launch_cyc_q[i] - launch_cyc_q[i-1]), 32'd4);
    end

    $display("[TB] baud change deferred while busy");
    doReset();
    busy_len = 20;
    applyStimulus(0, 8'h42);
    runTransaction(1'b0, 1'b0);
    br_select = 3'd6;
    rx_ready  = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("br_hold_busy", 32'(br_clocks), 32'd10417);
    waitTxReady(1'b1);
    repeat (3) @(negedge clk);
    checkOutput("br_hold_rx_busy", 32'(br_clocks), 32'd10417);
    drain();
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("br_updated", 32'(br_clocks), 32'd868);

    $display("[TB] baud change and grant in the same idle cycle");
    br_select = 3'd2;
    applyStimulus(3, 8'hC3);
    runTransaction(1'b0, 1'b0);
    drain();
    checkOutput("br_after_joint", 32'(br_clocks), 32'd6945);

    $display("[TB] randomized traffic");
    busy_rand = 1'b1;
    tx_d_max  = 2;
    repeat (150) runTransaction(1'b0, 1'b1);
    req = '0;
    drain();

    $display("[TB] reset in WAIT_DONE");
    busy_rand = 1'b0;
    busy_len  = 20;
    tx_d_max  = 0;
    applyStimulus(1, 8'h3C);
    runTransaction(1'b0, 1'b0);
    waitTxReady(1'b0);
    repeat (3) @(negedge clk);
    xfer_aborted = 1'b1;
    doReset();
    done_seen = '0;
    repeat (25) begin
      @(negedge clk);
      done_seen = done_seen | done;
    end
    checkOutput("no_done_after_abort", 32'(done_seen), 32'd0);
    observed_q.delete();
    applyStimulus(2, 8'h5A);
    runTransaction(1'b0, 1'b0);
    drain();
    if (observed_q.size() > 0) checkOutput("post_reset_winner", 32'(observed_q[0]), 32'd2);
    else timeoutFail("post_reset_no_grant");

`ifdef UART_TX_SCHED_LOCK_EN
    $display("[TB] locked packet from requester 0");
    doReset();
    busy_len = 3;
    observed_q.delete();
    lock = 4'b0001;
    applyStimulus(0, 8'h01);
    applyStimulus(1, 8'h02);
    repeat (3) runTransaction(1'b1, 1'b0);
    lock = '0;
    runTransaction(1'b0, 1'b0);
    req = '0;
    drain();
    checkOutput("lock_count", 32'(observed_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < observed_q.size()) checkOutput("lock_order", 32'(observed_q[i]), (i < 3) ? 32'd0 : 32'd1);
    end
`endif

    finishTest();
  end

endmodule
